sr_flop_bank: RTL and testbench
===============================

SR_FLOP_BANK -- requirements
Module: sr_flop_bank

Interface
REQ-001 The block SHALL take parameter N, default 8: number of independent set/reset channels, legal range 1..32.
REQ-002 The block SHALL take parameter MODE, default 0: S=R=1 resolution; 0 reset-dominant, 1 set-dominant, 2 toggle, 3 hold.
REQ-003 The block SHALL take parameter HOLD_CYC, default 0: lockout cycles after a q change, legal range 0..255; 0 disables lockout.
REQ-004 The block SHALL take parameter INIT, N bits, default all zero: per-channel reset value of q.
REQ-005 The block SHALL have clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have s, input, N bits: per-channel set request, level-sensitive.
REQ-008 The block SHALL have r, input, N bits: per-channel reset request, level-sensitive.
REQ-009 The block SHALL have clr, input, N bits: per-channel clear of the conflict flag.
REQ-010 The block SHALL have q, output, N bits: registered channel state.
REQ-011 The block SHALL have q0, output, N bits: the bitwise complement of q at all times.
REQ-012 The block SHALL have changed, output, N bits: one-cycle pulse in the cycle after q[i] changes.
REQ-013 The block SHALL have busy, output, N bits: channel i is in lockout.
REQ-014 The block SHALL have conflict, output, N bits: sticky flag, S=R=1 sampled on channel i.

Function
REQ-015 Each channel SHALL sample s[i]/r[i] at each rising edge and update q[i] at that edge, giving 1-cycle latency.
REQ-016 Update rules SHALL be: S=1,R=0 -> q=1; S=0,R=1 -> q=0; S=0,R=0 -> hold; S=R=1 -> resolved per MODE (0 -> 0, 1 -> 1, 2 -> ~q, 3 -> hold).
REQ-017 q0 SHALL never equal q; no forbidden or metastable-looking state is exposed.
REQ-018 When q[i] changes and HOLD_CYC>0, the lockout counter SHALL load HOLD_CYC and busy[i] SHALL assert from the next cycle.
REQ-019 While busy[i] is asserted, s[i]/r[i] SHALL be ignored for q, and the counter SHALL decrement once per cycle; busy[i] deasserts when it reaches 0, so lockout lasts exactly HOLD_CYC cycles.
REQ-020 The counter width SHALL be $clog2(HOLD_CYC+1); when HOLD_CYC=0, busy SHALL be constant 0.
REQ-021 conflict[i] SHALL set on any sampled S=R=1, including during lockout, and stay set until clr[i].
REQ-022 When a new conflict and clr[i] occur in the same cycle, conflict[i] SHALL end that cycle set (the new event wins).
REQ-023 changed[i] SHALL be a registered pulse, high for exactly one cycle per q[i] transition; in MODE 2 a sustained S=R=1 outside lockout SHALL toggle q every cycle and pulse changed every cycle.
REQ-024 Channels SHALL be fully independent; no cross-channel priority.

Reset
REQ-025 On rst assertion, q SHALL go to INIT and q0 to ~INIT immediately; changed, busy, conflict and all lockout counters SHALL go to 0.
REQ-026 Reset asserted mid-lockout SHALL abort the lockout; after release, the first edge SHALL honour s/r normally.
REQ-027 Reset release SHALL NOT itself produce a changed pulse.

Configuration
REQ-028 With macro SR_FLOP_BANK_SYNC_EN defined, s, r and clr SHALL each pass through a 2-flop synchroniser (reset to 0), raising s/r-to-q latency to 3 cycles; without it, inputs are sampled directly with 1-cycle latency and no synchroniser flops exist.

Structure
REQ-029 Package sr_bank_pkg SHALL hold the MODE encodings (SR_RST_DOM=0, SR_SET_DOM=1, SR_TOGGLE=2, SR_HOLD=3) and the N/HOLD_CYC legal-range limits.
REQ-030 One channel (q register, lockout counter, changed and conflict logic) SHALL be sub-module sr_flop_chan, instantiated N times via generate; synchronisers reside in the top.

Verification
REQ-031 N=4, MODE=0, INIT=4'b0101, HOLD_CYC=0: assert rst -> q=0101, q0=1010, busy=conflict=changed=0.
REQ-032 MODE=0: s[0]=1 for one cycle -> q[0]=1 next edge, changed[0] one pulse; then s[0]=r[0]=1 -> q[0]=0, conflict[0]=1 until clr[0] pulse.
REQ-033 MODE=2, HOLD_CYC=0: s[1]=r[1]=1 held for 4 cycles from q[1]=0 -> q[1] sequence 1,0,1,0, changed[1] high all 4 cycles.
REQ-034 HOLD_CYC=3: s[2]=1 sets q[2]; r[2]=1 held -> busy[2] high 3 cycles, q[2] stays 1, clears on the 4th edge after the set.
REQ-035 HOLD_CYC=5: rst pulsed 2 cycles into lockout -> busy=0 immediately; after release, r[2]=1 clears q[2] on the first edge.
REQ-036 SR_FLOP_BANK_SYNC_EN defined: s[3] rising -> q[3] rises on the 3rd edge; simultaneous conflict and clr on channel 3 -> conflict[3] remains 1.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the set/reset flop bank.
// Contents:
//   - MODE encodings that decide what happens when s and r are both high.
//   - Legal ranges for the N and HOLD_CYC parameters.
//   - sr_next(): the next-state function of a single set/reset channel.
package sr_bank_pkg;

  // Resolution applied when s and r are both high.
  localparam int unsigned SR_RST_DOM = 0;  // reset wins, q -> 0
  localparam int unsigned SR_SET_DOM = 1;  // set wins, q -> 1
  localparam int unsigned SR_TOGGLE  = 2;  // q -> ~q
  localparam int unsigned SR_HOLD    = 3;  // q unchanged

  // Legal parameter ranges.
  localparam int unsigned N_MIN        = 1;
  localparam int unsigned N_MAX        = 32;
  localparam int unsigned HOLD_CYC_MIN = 0;
  localparam int unsigned HOLD_CYC_MAX = 255;

  // Next value of one channel, ignoring lockout.
  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input int unsigned mode);
    logic nxt;
    nxt = q;
    if (s && !r) begin
      nxt = 1'b1;
    end else if (!s && r) begin
      nxt = 1'b0;
    end else if (s && r) begin
      case (mode)
        SR_RST_DOM: nxt = 1'b0;
        SR_SET_DOM: nxt = 1'b1;
        SR_TOGGLE:  nxt = ~q;
        default:    nxt = q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_flop_chan.sv
// One set/reset channel of the flop bank.
// Behaviour:
//   - The registered q follows s/r with one clock of latency.
//   - After each change of q there is an optional lockout of HOLD_CYC cycles, during which
//     s/r are ignored.
//   - changed is a registered pulse, high for one cycle after each change of q.
//   - conflict is a sticky flag that records s=r=1.
// Parameters:
//   MODE     - how s=r=1 is resolved (encodings in sr_bank_pkg)
//   HOLD_CYC - number of lockout cycles after a change; 0 means no lockout
//   INIT     - value q takes while rst is high
// Ports:
//   clk, rst          - clock; reset is asynchronous and active-high
//   s, r, clr         - set request, reset request, clear for the conflict flag
//   q                 - registered state
//   changed           - one-cycle pulse after q changes
//   busy              - channel is in lockout
//   conflict          - sticky flag, set when s=r=1 is sampled
module sr_flop_chan
  import sr_bank_pkg::*;
#(
  parameter int unsigned MODE     = SR_RST_DOM,
  parameter int unsigned HOLD_CYC = 0,
  parameter logic        INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr,
  output logic q,
  output logic changed,
  output logic busy,
  output logic conflict
);

  logic q_q, q_d;
  logic changed_q;
  logic conflict_q, conflict_d;
  logic locked;

  always_comb begin
    q_d = q_q;
    if (!locked) begin
      q_d = sr_next(s, r, q_q, MODE);
    end
    // A new conflict beats a simultaneous clear.
    conflict_d = (s & r) | (conflict_q & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= INIT;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= q_d ^ q_q;
      conflict_q <= conflict_d;
    end
  end

  if (HOLD_CYC == 0) begin : g_no_lock
    assign locked = 1'b0;
  end else begin : g_lock
    localparam int unsigned CntW = $clog2(HOLD_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // q cannot change while locked, so reloading and counting down never coincide.
    always_comb begin
      cnt_d = cnt_q;
      if (q_d != q_q) begin
        cnt_d = CntW'(HOLD_CYC);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign locked = (cnt_q != '0);
  end

  assign q        = q_q;
  assign changed  = changed_q;
  assign busy     = locked;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent set/reset flops. There is no priority between channels.
// Parameters:
//   N        - number of channels (1..32)
//   MODE     - how s=r=1 is resolved (sr_bank_pkg encodings)
//   HOLD_CYC - lockout cycles after a change of q (0..255); 0 disables lockout
//   INIT     - reset value of q, one bit per channel
// Ports:
//   clk, rst                  - clock; reset is asynchronous and active-high
//   s, r, clr  [N-1:0]        - set request, reset request, conflict clear
//   q, q0      [N-1:0]        - registered state and its complement
//   changed    [N-1:0]        - one-cycle pulse after q changes
//   busy       [N-1:0]        - channel is in lockout
//   conflict   [N-1:0]        - sticky s=r=1 flag
// Build option:
//   SR_FLOP_BANK_SYNC_EN - when defined, s, r and clr each pass through a 2-flop
//                          synchroniser, which makes the s/r-to-q latency 3 cycles.
module sr_flop_bank
  import sr_bank_pkg::*;
#(
  parameter int unsigned   N        = 8,
  parameter int unsigned   MODE     = SR_RST_DOM,
  parameter int unsigned   HOLD_CYC = 0,
  parameter logic [N-1:0]  INIT     = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  input  logic [N-1:0] clr,
  output logic [N-1:0] q,
  output logic [N-1:0] q0,
  output logic [N-1:0] changed,
  output logic [N-1:0] busy,
  output logic [N-1:0] conflict
);

  logic [N-1:0] s_y, r_y, clr_y;

`ifdef SR_FLOP_BANK_SYNC_EN
  logic [N-1:0] s_m, r_m, clr_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_m   <= '0;
      r_m   <= '0;
      clr_m <= '0;
      s_y   <= '0;
      r_y   <= '0;
      clr_y <= '0;
    end else begin
      s_m   <= s;
      r_m   <= r;
      clr_m <= clr;
      s_y   <= s_m;
      r_y   <= r_m;
      clr_y <= clr_m;
    end
  end
`else
  assign s_y   = s;
  assign r_y   = r;
  assign clr_y = clr;
`endif

  for (genvar i = 0; i < N; i++) begin : g_chan
    sr_flop_chan #(
      .MODE     (MODE),
      .HOLD_CYC (HOLD_CYC),
      .INIT     (INIT[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s        (s_y[i]),
      .r        (r_y[i]),
      .clr      (clr_y[i]),
      .q        (q[i]),
      .changed  (changed[i]),
      .busy     (busy[i]),
      .conflict (conflict[i])
    );
  end

  assign q0 = ~q;

endmodule

// File: tb/tb_sr_flop_bank.sv
module tb_sr_flop_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: MODE 0, INIT 0101, no lockout   b: MODE 2 (toggle)
  // c: MODE 0, HOLD_CYC 3              d: MODE 0, HOLD_CYC 5, INIT 0100
  logic [3:0] s_a, r_a, clr_a, q_a, q0_a, chg_a, busy_a, cf_a;
  logic [3:0] s_b, r_b, clr_b, q_b, q0_b, chg_b, busy_b, cf_b;
  logic [3:0] s_c, r_c, clr_c, q_c, q0_c, chg_c, busy_c, cf_c;
  logic [3:0] s_d, r_d, clr_d, q_d, q0_d, chg_d, busy_d, cf_d;

  sr_flop_bank #(.N(4), .MODE(0), .HOLD_CYC(0), .INIT(4'b0101)) u_dut_a (
    .clk(clk), .rst(rst), .s(s_a), .r(r_a), .clr(clr_a),
    .q(q_a), .q0(q0_a), .changed(chg_a), .busy(busy_a), .conflict(cf_a)
  );
  sr_flop_bank #(.N(4), .MODE(2), .HOLD_CYC(0), .INIT(4'b0000)) u_dut_b (
    .clk(clk), .rst(rst), .s(s_b), .r(r_b), .clr(clr_b),
    .q(q_b), .q0(q0_b), .changed(chg_b), .busy(busy_b), .conflict(cf_b)
  );
  sr_flop_bank #(.N(4), .MODE(0), .HOLD_CYC(3), .INIT(4'b0000)) u_dut_c (
    .clk(clk), .rst(rst), .s(s_c), .r(r_c), .clr(clr_c),
    .q(q_c), .q0(q0_c), .changed(chg_c), .busy(busy_c), .conflict(cf_c)
  );
  sr_flop_bank #(.N(4), .MODE(0), .HOLD_CYC(5), .INIT(4'b0100)) u_dut_d (
    .clk(clk), .rst(rst), .s(s_d), .r(r_d), .clr(clr_d),
    .q(q_d), .q0(q0_d), .changed(chg_d), .busy(busy_d), .conflict(cf_d)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {s_a, r_a, clr_a, s_b, r_b, clr_b} = '0;
    {s_c, r_c, clr_c, s_d, r_d, clr_d} = '0;
    rst = 1'b1;
    #2;
    check("rst_q_a", 32'(q_a), 32'h5);
    check("rst_q0_a", 32'(q0_a), 32'ha);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_conf_a", 32'(cf_a), 32'h0);
    check("rst_chg_a", 32'(chg_a), 32'h0);
    check("rst_q_d", 32'(q_d), 32'h4);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rel_chg_a", 32'(chg_a), 32'h0);
    check("rel_q_a", 32'(q_a), 32'h5);

`ifdef SR_FLOP_BANK_SYNC_EN
    s_a = 4'b1000;
    tick(); check("sync_q_e1", 32'(q_a), 32'h5);
    tick(); check("sync_q_e2", 32'(q_a), 32'h5);
    tick(); check("sync_q_e3", 32'(q_a), 32'hd);
    r_a = 4'b1000;
    repeat (3) tick();
    check("sync_conf_set", 32'(cf_a), 32'h8);
    clr_a = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sync_conf_vs_clr", 32'(cf_a), 32'h8);
    end
    s_a = '0;
    r_a = '0;
    repeat (3) tick();
    check("sync_conf_clr", 32'(cf_a), 32'h0);
    clr_a = '0;
`else
    // Channel 0 on bank a: reset, set, then a conflict.
    r_a = 4'b0001;
    tick(); check("a_r0_q", 32'(q_a), 32'h4); check("a_r0_chg", 32'(chg_a), 32'h1);
    r_a = '0;
    tick(); check("a_chg_one_cyc", 32'(chg_a), 32'h0);
    s_a = 4'b0001;
    tick(); check("a_s0_q", 32'(q_a), 32'h5); check("a_s0_chg", 32'(chg_a), 32'h1);
    s_a = '0;
    tick(); check("a_s0_chg_end", 32'(chg_a), 32'h0);
    s_a = 4'b0001;
    r_a = 4'b0001;
    tick(); check("a_sr_q", 32'(q_a), 32'h4); check("a_sr_conf", 32'(cf_a), 32'h1);
    s_a = '0;
    r_a = '0;
    tick(); check("a_conf_sticky1", 32'(cf_a), 32'h1);
    tick(); check("a_conf_sticky2", 32'(cf_a), 32'h1);
    clr_a = 4'b0001;
    tick(); check("a_conf_clr", 32'(cf_a), 32'h0);
    clr_a = '0;
    // New conflict together with clr: the conflict wins.
    s_a = 4'b0100;
    r_a = 4'b0100;
    tick(); check("a_c2_conf", 32'(cf_a), 32'h4); check("a_c2_q", 32'(q_a), 32'h0);
    clr_a = 4'b0100;
    tick(); check("a_c2_conf_vs_clr", 32'(cf_a), 32'h4);
    s_a = '0;
    r_a = '0;
    tick(); check("a_c2_conf_clr", 32'(cf_a), 32'h0);
    clr_a = '0;
    // Independent channels.
    s_a = 4'b0011;
    r_a = 4'b1100;
    tick();
    check("a_mix_q", 32'(q_a), 32'h3);
    check("a_mix_q0", 32'(q0_a), 32'hc);
    check("a_mix_chg", 32'(chg_a), 32'h3);
    check("a_busy_zero", 32'(busy_a), 32'h0);
    s_a = '0;
    r_a = '0;

    // Toggle mode: s=r=1 held for 4 cycles.
    s_b = 4'b0010;
    r_b = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_tog_q", 32'(q_b), (i % 2 == 0) ? 32'h2 : 32'h0);
      check("b_tog_chg", 32'(chg_b), 32'h2);
    end
    check("b_tog_conf", 32'(cf_b), 32'h2);
    s_b = '0;
    r_b = '0;
    tick(); check("b_tog_chg_end", 32'(chg_b), 32'h0);

    // Lockout of 3 cycles.
    s_c = 4'b0100;
    tick(); check("c_set_q", 32'(q_c), 32'h4); check("c_busy_e0", 32'(busy_c), 32'h4);
    s_c = '0;
    r_c = 4'b0100;
    tick(); check("c_q_e1", 32'(q_c), 32'h4); check("c_busy_e1", 32'(busy_c), 32'h4);
    tick(); check("c_q_e2", 32'(q_c), 32'h4); check("c_busy_e2", 32'(busy_c), 32'h4);
    tick(); check("c_q_e3", 32'(q_c), 32'h4); check("c_busy_e3", 32'(busy_c), 32'h0);
    tick(); check("c_q_e4", 32'(q_c), 32'h0); check("c_busy_e4", 32'(busy_c), 32'h4);
    r_c = '0;

    // Lockout of 5 cycles, aborted by reset.
    r_d = 4'b0100;
    tick(); check("d_clr_q", 32'(q_d), 32'h0); check("d_busy", 32'(busy_d), 32'h4);
    r_d = '0;
    s_d = 4'b0100;
    tick(); check("d_locked_q", 32'(q_d), 32'h0);
    tick();
    s_d = '0;
    r_d = 4'b0100;
    rst = 1'b1;
    #1;
    check("d_rst_busy", 32'(busy_d), 32'h0);
    check("d_rst_q", 32'(q_d), 32'h4);
    tick();
    rst = 1'b0;
    tick();
    check("d_post_rst_q", 32'(q_d), 32'h0);
    check("d_post_rst_chg", 32'(chg_d), 32'h4);
    r_d = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
